// File: rtl/psx_pad_emulator_if.sv
// PSX pad bus bundle.
//   master: console/host side, drives psx_clk, cmd, att (all async to clk)
//           and the live pad state buttons/sticks/mode_analog.
//   slave : the pad emulator, drives data/ack back to the console and
//           reports received command bytes (cmd_byte, cmd_valid, byte_idx).
interface psx_pad_emulator_if;
  logic        psx_clk;
  logic        cmd;
  logic        att;
  logic [15:0] buttons;
  logic [31:0] sticks;
  logic        mode_analog;
  logic        data;
  logic        ack;
  logic [7:0]  cmd_byte;
  logic        cmd_valid;
  logic [3:0]  byte_idx;

  modport master (
    output psx_clk, cmd, att, buttons, sticks, mode_analog,
    input  data, ack, cmd_byte, cmd_valid, byte_idx
  );

  modport slave (
    input  psx_clk, cmd, att, buttons, sticks, mode_analog,
    output data, ack, cmd_byte, cmd_valid, byte_idx
  );
endinterface

// File: rtl/psx_pad_emulator.sv
// PSX controller emulator running on the system clock.
// Oversamples the console's psx_clk/cmd/att, shifts a 5-byte digital
// (ID 0x41) or 9-byte analog (ID 0x73) poll response out LSB first,
// checks the 0x01/0x42 command header and generates ack from clk.
//   clk, rst : system clock (>= 8x psx_clk), async active-high reset
//   pad      : slave side of psx_pad_emulator_if
module psx_pad_emulator #(
  parameter int unsigned ACK_DELAY = 8,
  parameter int unsigned ACK_WIDTH = 4,
  parameter bit          ANALOG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  psx_pad_emulator_if.slave pad
);

  typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, DONE, IGNORE} state_t;

  state_t      state_q;
  logic [2:0]  pclk_sync_q, att_sync_q;  // [1] = synced, [2] = previous
  logic [1:0]  cmd_sync_q;
  logic [1:0]  flush_q;
  logic        arm_q;
  logic [47:0] snap_q;                   // {sticks, buttons} at att fall
  logic        analog_q;
  logic [7:0]  sh_q, cnt_q, cmd_byte_q;
  logic [2:0]  bit_q;
  logic [3:0]  byte_idx_q;
  logic        data_q, ack_q, cmd_valid_q;

  logic        psx_rise, psx_fall, att_rise, att_fall;
  logic [7:0]  sh_d, cur_byte, nxt_byte;
  logic [3:0]  last_idx;

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic an,
                                            input logic [47:0] snap);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hFF;
      4'd1:    b = an ? 8'h73 : 8'h41;
      4'd2:    b = 8'h5A;
      4'd3:    b = snap[7:0];
      4'd4:    b = snap[15:8];
      4'd5:    b = snap[23:16];
      4'd6:    b = snap[31:24];
      4'd7:    b = snap[39:32];
      4'd8:    b = snap[47:40];
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  assign psx_rise = pclk_sync_q[1] & ~pclk_sync_q[2];
  assign psx_fall = ~pclk_sync_q[1] & pclk_sync_q[2];
  assign att_rise = att_sync_q[1] & ~att_sync_q[2];
  assign att_fall = ~att_sync_q[1] & att_sync_q[2];
  assign sh_d     = {cmd_sync_q[1], sh_q[7:1]};
  assign cur_byte = frame_byte(byte_idx_q, analog_q, snap_q);
  assign nxt_byte = frame_byte(byte_idx_q + 4'd1, analog_q, snap_q);
  assign last_idx = analog_q ? 4'd8 : 4'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_sync_q <= '1;
      att_sync_q  <= '1;
      cmd_sync_q  <= '1;
    end else begin
      pclk_sync_q <= {pclk_sync_q[1:0], pad.psx_clk};
      att_sync_q  <= {att_sync_q[1:0], pad.att};
      cmd_sync_q  <= {cmd_sync_q[0], pad.cmd};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_q     <= '0;
      arm_q       <= 1'b0;
      snap_q      <= '0;
      analog_q    <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      cmd_byte_q  <= '0;
      bit_q       <= '0;
      byte_idx_q  <= '0;
      data_q      <= 1'b1;
      ack_q       <= 1'b1;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      // The att synchroniser is preset high, so att held low through reset
      // would look like a fall. Frames are only accepted once att has been
      // seen high with the synchroniser flushed.
      flush_q <= {flush_q[0], 1'b1};
      if (&flush_q && att_sync_q[1]) arm_q <= 1'b1;

      if (att_rise) begin
        state_q    <= IDLE;
        data_q     <= 1'b1;
        ack_q      <= 1'b1;
        byte_idx_q <= '0;
        bit_q      <= '0;
        cnt_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            // psx_clk edges here (including one coincident with att fall)
            // are dropped; shifting begins at the first rise in SHIFT.
            if (att_fall && arm_q) begin
              snap_q     <= {pad.sticks, pad.buttons};
              analog_q   <= ANALOG_EN & pad.mode_analog;
              byte_idx_q <= '0;
              bit_q      <= '0;
              data_q     <= 1'b1;  // byte 0 is 0xFF
              state_q    <= SHIFT;
            end
          end
          SHIFT: begin
            if (psx_rise) begin
              sh_q  <= sh_d;
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                cmd_byte_q  <= sh_d;
                cmd_valid_q <= 1'b1;
                if ((byte_idx_q == 4'd0 && sh_d != 8'h01) ||
                    (byte_idx_q == 4'd1 && sh_d != 8'h42)) begin
                  data_q  <= 1'b1;
                  state_q <= IGNORE;
                end else if (byte_idx_q == last_idx) begin
                  data_q  <= 1'b1;
                  state_q <= DONE;
                end else begin
                  cnt_q   <= 8'(ACK_DELAY - 1);
                  state_q <= ACK_WAIT;
                end
              end
            end else if (psx_fall && bit_q != 3'd0) begin
              data_q <= cur_byte[bit_q];
            end
          end
          ACK_WAIT: begin
            if (cnt_q == 8'd0) begin
              ack_q   <= 1'b0;
              cnt_q   <= 8'(ACK_WIDTH - 1);
              state_q <= ACK_PULSE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          ACK_PULSE: begin
            if (cnt_q == 8'd0) begin
              ack_q      <= 1'b1;
              byte_idx_q <= byte_idx_q + 4'd1;
              bit_q      <= '0;
              data_q     <= nxt_byte[0];
              state_q    <= SHIFT;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          DONE, IGNORE: begin
            data_q <= 1'b1;
            ack_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pad.data      = data_q;
  assign pad.ack       = ack_q;
  assign pad.cmd_byte  = cmd_byte_q;
  assign pad.cmd_valid = cmd_valid_q;
  assign pad.byte_idx  = byte_idx_q;

endmodule

// File: tb/tb_psx_pad_emulator.sv
module tb_psx_pad_emulator;
  localparam int ACK_DELAY = 8;
  localparam int ACK_WIDTH = 4;
  localparam int HALF      = 8;  // clk cycles per psx_clk half period

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psx_clk = 1'b1, cmd = 1'b1, att = 1'b1, mode_analog = 1'b0;
  logic [15:0] buttons = 16'hFFFF;
  logic [31:0] sticks = 32'h0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  psx_pad_emulator_if ifa ();
  psx_pad_emulator_if ifd ();
  assign ifa.psx_clk = psx_clk;  assign ifd.psx_clk = psx_clk;
  assign ifa.cmd = cmd;          assign ifd.cmd = cmd;
  assign ifa.att = att;          assign ifd.att = att;
  assign ifa.buttons = buttons;  assign ifd.buttons = buttons;
  assign ifa.sticks = sticks;    assign ifd.sticks = sticks;
  assign ifa.mode_analog = mode_analog;
  assign ifd.mode_analog = mode_analog;

  psx_pad_emulator #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH), .ANALOG_EN(1'b1))
    dut_a (.clk(clk), .rst(rst), .pad(ifa.slave));
  psx_pad_emulator #(.ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH), .ANALOG_EN(1'b0))
    dut_d (.clk(clk), .rst(rst), .pad(ifd.slave));

  // Monitors: log every cmd_valid byte and count ack falling edges.
  int         nval_a = 0, nval_d = 0, acks_a = 0, acks_d = 0;
  logic [7:0] vlog_a [1024];
  logic [7:0] vlog_d [1024];
  logic       ack_prev_a = 1'b1, ack_prev_d = 1'b1;
  always @(negedge clk) begin
    if (ifa.cmd_valid === 1'b1) begin
      vlog_a[nval_a % 1024] <= ifa.cmd_byte;
      nval_a <= nval_a + 1;
    end
    if (ifd.cmd_valid === 1'b1) begin
      vlog_d[nval_d % 1024] <= ifd.cmd_byte;
      nval_d <= nval_d + 1;
    end
    if (ifa.ack === 1'b0 && ack_prev_a) acks_a <= acks_a + 1;
    if (ifd.ack === 1'b0 && ack_prev_d) acks_d <= acks_d + 1;
    ack_prev_a <= (ifa.ack !== 1'b0);
    ack_prev_d <= (ifd.ack !== 1'b0);
  end

  // Reference model: response byte k of a frame, and the byte index at which
  // the pad stops responding (header mismatch or last byte of the frame).
  function automatic logic [7:0] model_byte(input int k, input logic an,
                                            input logic [15:0] b, input logic [31:0] s);
    case (k)
      0: return 8'hFF;
      1: return an ? 8'h73 : 8'h41;
      2: return 8'h5A;
      3: return b[7:0];
      4: return b[15:8];
      5: return s[7:0];
      6: return s[15:8];
      7: return s[23:16];
      default: return s[31:24];
    endcase
  endfunction

  function automatic int model_stop(input logic [7:0] c0, input logic [7:0] c1, input logic an);
    if (c0 != 8'h01) return 0;
    if (c1 != 8'h42) return 1;
    return an ? 8 : 4;
  endfunction

  task automatic send_byte(input logic [7:0] c, input int nbits,
                           output logic [7:0] ra, output logic [7:0] rd);
    ra = 8'hFF;
    rd = 8'hFF;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk);
      psx_clk = 1'b0;
      cmd = c[k];
      repeat (HALF) @(negedge clk);
      ra[k] = ifa.data;
      rd[k] = ifd.data;
      psx_clk = 1'b1;
      if (k != nbits - 1) repeat (HALF) @(negedge clk);
    end
  endtask

  // Called right after the 8th rise was driven.
  task automatic ack_phase(input bit exp_ack, input string tag);
    int n, w;
    if (exp_ack) begin
      n = 0;
      while (ifa.ack !== 1'b0 && n < 600) begin @(posedge clk); #1; n++; end
      checks++;
      if (n != ACK_DELAY + 3) begin
        errors++;
        $display("FAIL %s ack_delay: got %0d clk, expected %0d", tag, n, ACK_DELAY + 3);
      end
      w = 0;
      while (ifa.ack === 1'b0 && w < 600) begin @(posedge clk); #1; w++; end
      checks++;
      if (w != ACK_WIDTH) begin
        errors++;
        $display("FAIL %s ack_width: got %0d clk, expected %0d", tag, w, ACK_WIDTH);
      end
    end else begin
      repeat (ACK_DELAY + ACK_WIDTH + 8) @(negedge clk);
    end
  endtask

  task automatic poll(input logic [7:0] c [9], input int nsend, input string tag);
    logic [15:0] b;
    logic [31:0] s;
    logic        m;
    logic [7:0]  ra, rd, ea, ed;
    int          sa, sd, va0, vd0, aa0, ad0;
    b = buttons; s = sticks; m = mode_analog;
    sa = model_stop(c[0], c[1], m);
    sd = model_stop(c[0], c[1], 1'b0);
    va0 = nval_a; vd0 = nval_d; aa0 = acks_a; ad0 = acks_d;
    att = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nsend; i++) begin
      send_byte(c[i], 8, ra, rd);
      ea = (i <= sa) ? model_byte(i, m, b, s) : 8'hFF;
      ed = (i <= sd) ? model_byte(i, 1'b0, b, s) : 8'hFF;
      checks += 2;
      if (ra !== ea) begin
        errors++;
        $display("FAIL %s data_a byte%0d: got %h expected %h", tag, i, ra, ea);
      end
      if (rd !== ed) begin
        errors++;
        $display("FAIL %s data_d byte%0d: got %h expected %h", tag, i, rd, ed);
      end
      // Inputs moving mid-frame must not affect the snapshot.
      if (i == 0) begin
        buttons = 16'($urandom); sticks = $urandom; mode_analog = 1'($urandom);
      end
      ack_phase(i < sa, $sformatf("%s byte%0d", tag, i));
      repeat (HALF) @(negedge clk);
    end
    checks += 6;
    if (ifa.byte_idx !== 4'(sa)) begin
      errors++; $display("FAIL %s byte_idx_a: got %0d expected %0d", tag, ifa.byte_idx, sa);
    end
    if (ifd.byte_idx !== 4'(sd)) begin
      errors++; $display("FAIL %s byte_idx_d: got %0d expected %0d", tag, ifd.byte_idx, sd);
    end
    if (nval_a - va0 != sa + 1) begin
      errors++; $display("FAIL %s valid_cnt_a: got %0d expected %0d", tag, nval_a - va0, sa + 1);
    end
    if (nval_d - vd0 != sd + 1) begin
      errors++; $display("FAIL %s valid_cnt_d: got %0d expected %0d", tag, nval_d - vd0, sd + 1);
    end
    if (acks_a - aa0 != sa) begin
      errors++; $display("FAIL %s ack_cnt_a: got %0d expected %0d", tag, acks_a - aa0, sa);
    end
    if (acks_d - ad0 != sd) begin
      errors++; $display("FAIL %s ack_cnt_d: got %0d expected %0d", tag, acks_d - ad0, sd);
    end
    for (int k = 0; k <= sa && k < nval_a - va0; k++) begin
      checks++;
      if (vlog_a[(va0 + k) % 1024] !== c[k]) begin
        errors++;
        $display("FAIL %s cmd_byte_a%0d: got %h expected %h", tag, k, vlog_a[(va0 + k) % 1024], c[k]);
      end
    end
    for (int k = 0; k <= sd && k < nval_d - vd0; k++) begin
      checks++;
      if (vlog_d[(vd0 + k) % 1024] !== c[k]) begin
        errors++;
        $display("FAIL %s cmd_byte_d%0d: got %h expected %h", tag, k, vlog_d[(vd0 + k) % 1024], c[k]);
      end
    end
    att = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 2;
    if ({ifa.data, ifa.ack, ifa.cmd_byte, ifa.cmd_valid, ifa.byte_idx} !== {1'b1, 1'b1, 8'h00, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_a: got d=%b a=%b cb=%h cv=%b bi=%0d expected d=1 a=1 cb=00 cv=0 bi=0",
               ifa.data, ifa.ack, ifa.cmd_byte, ifa.cmd_valid, ifa.byte_idx);
    end
    if ({ifd.data, ifd.ack, ifd.cmd_byte, ifd.cmd_valid, ifd.byte_idx} !== {1'b1, 1'b1, 8'h00, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL reset_d: got d=%b a=%b cb=%h cv=%b bi=%0d expected d=1 a=1 cb=00 cv=0 bi=0",
               ifd.data, ifd.ack, ifd.cmd_byte, ifd.cmd_valid, ifd.byte_idx);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_digital();
    logic [7:0] c [9];
    c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    buttons = 16'hBF7F; mode_analog = 1'b0;
    poll(c, 5, "digital");
  endtask

  // dut_d (ANALOG_EN=0) sees the same frame and must answer digitally.
  task automatic test_analog();
    logic [7:0] c [9];
    c = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    buttons = 16'hFFFF; sticks = 32'h80807F10; mode_analog = 1'b1;
    poll(c, 9, "analog");
  endtask

  task automatic test_wrong_addr();
    logic [7:0] c [9];
    c = '{8'h02, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    buttons = 16'h1234; mode_analog = 1'b0;
    poll(c, 5, "wrong_addr");
    test_digital();
  endtask

  task automatic test_abort();
    logic [7:0] ra, rd;
    int va0, aa0;
    buttons = 16'h0000; mode_analog = 1'b0;
    va0 = nval_a; aa0 = acks_a;
    att = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h01, 8, ra, rd); ack_phase(1'b1, "abort byte0"); repeat (HALF) @(negedge clk);
    send_byte(8'h42, 8, ra, rd); ack_phase(1'b1, "abort byte1"); repeat (HALF) @(negedge clk);
    send_byte(8'h00, 8, ra, rd); ack_phase(1'b1, "abort byte2"); repeat (HALF) @(negedge clk);
    send_byte(8'h00, 3, ra, rd);
    repeat (HALF) @(negedge clk);
    checks++;
    if (ifa.data !== 1'b0) begin
      errors++; $display("FAIL abort pre_data: got %b expected 0", ifa.data);
    end
    att = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks += 2;
    if (ifa.data !== 1'b1) begin errors++; $display("FAIL abort data: got %b expected 1", ifa.data); end
    if (ifa.ack !== 1'b1) begin errors++; $display("FAIL abort ack: got %b expected 1", ifa.ack); end
    repeat (20) @(negedge clk);
    checks += 3;
    if (nval_a - va0 != 3) begin
      errors++; $display("FAIL abort valid_cnt: got %0d expected 3", nval_a - va0);
    end
    if (acks_a - aa0 != 3) begin
      errors++; $display("FAIL abort ack_cnt: got %0d expected 3", acks_a - aa0);
    end
    if (ifa.byte_idx !== 4'd0) begin
      errors++; $display("FAIL abort byte_idx: got %0d expected 0", ifa.byte_idx);
    end
    test_digital();
  endtask

  task automatic test_reset_mid_ack();
    logic [7:0] ra, rd;
    int n, va0, aa0;
    buttons = 16'h00FF; mode_analog = 1'b1;
    att = 1'b0;
    repeat (6) @(negedge clk);
    send_byte(8'h01, 8, ra, rd);
    n = 0;
    while (ifa.ack !== 1'b0 && n < 600) begin @(posedge clk); #1; n++; end
    checks++;
    if (ifa.ack !== 1'b0) begin errors++; $display("FAIL rst_ack wait: got ack=%b expected 0", ifa.ack); end
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if ({ifa.data, ifa.ack, ifa.cmd_byte, ifa.byte_idx} !== {1'b1, 1'b1, 8'h00, 4'h0}) begin
      errors++;
      $display("FAIL rst_ack outputs: got d=%b a=%b cb=%h bi=%0d expected d=1 a=1 cb=00 bi=0",
               ifa.data, ifa.ack, ifa.cmd_byte, ifa.byte_idx);
    end
    if ({ifd.data, ifd.ack} !== 2'b11) begin
      errors++; $display("FAIL rst_ack outputs_d: got %b expected 11", {ifd.data, ifd.ack});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    va0 = nval_a; aa0 = acks_a;
    repeat (10) @(negedge clk);
    // att is still low: no frame may start.
    send_byte(8'h01, 8, ra, rd);
    repeat (30) @(negedge clk);
    checks++;
    if (ra !== 8'hFF) begin errors++; $display("FAIL rst_ack byte0 data: got %h expected ff", ra); end
    send_byte(8'h42, 8, ra, rd);
    repeat (30) @(negedge clk);
    checks += 4;
    if (ra !== 8'hFF) begin errors++; $display("FAIL rst_ack byte1 data: got %h expected ff", ra); end
    if (nval_a - va0 != 0) begin
      errors++; $display("FAIL rst_ack valid_cnt: got %0d expected 0", nval_a - va0);
    end
    if (acks_a - aa0 != 0) begin
      errors++; $display("FAIL rst_ack ack_cnt: got %0d expected 0", acks_a - aa0);
    end
    if (ifa.cmd_byte !== 8'h00) begin
      errors++; $display("FAIL rst_ack cmd_byte: got %h expected 00", ifa.cmd_byte);
    end
    att = 1'b1;
    repeat (10) @(negedge clk);
    test_digital();
  endtask

  task automatic test_random();
    logic [7:0] c [9];
    int n;
    for (int f = 0; f < 6; f++) begin
      buttons = 16'($urandom); sticks = $urandom; mode_analog = 1'($urandom);
      for (int k = 0; k < 9; k++) c[k] = 8'($urandom);
      c[0] = ($urandom_range(0, 5) == 0) ? 8'h02 : 8'h01;
      c[1] = ($urandom_range(0, 5) == 0) ? 8'h43 : 8'h42;
      n = mode_analog ? 9 : 5;
      poll(c, n, $sformatf("random%0d", f));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_digital();
    test_analog();
    test_wrong_addr();
    test_abort();
    test_reset_mid_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
